// File: rtl/uart_tx_channel.sv
// Transmit datapath for one UART channel: byte FIFO fed by TDR writes, serialiser
// producing 8-bit frames with optional parity and one or two stop bits.
module uart_tx_channel #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4,
  parameter int DIV_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_write,
  input  logic [7:0]         tdr,
  input  logic               tx_reset,
  input  logic               sr_read,
  input  logic [DIV_W-1:0]   baud_div,
  input  logic               parity_en,
  input  logic               parity_odd,
  input  logic               two_stop,
  output logic               txd,
  output logic [FIFO_AW:0]   tx_count,
  output logic               tx_empty,
  output logic               tx_full,
  output logic               tx_idle,
  output logic               tx_overrun
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [2:0]         state;
  logic [7:0]         shift_q;
  logic [2:0]         bit_cnt;
  logic [DIV_W-1:0]   baud_cnt;
  logic [DIV_W-1:0]   div_q;
  logic               par_en_q;
  logic               par_bit_q;
  logic               two_stop_q;
  logic               push;
  logic               pop;
  logic               overrun_set;
  logic               baud_end;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == COUNT_FULL);
  assign tx_idle  = tx_empty && (state == S_IDLE);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
  assign pop         = !tx_reset && (state == S_IDLE) && !tx_empty;
  assign push        = !tx_reset && tx_write && (!tx_full || pop);
  assign overrun_set = !tx_reset && tx_write && tx_full && !pop;
  assign baud_end    = (baud_cnt == div_q - DIV_W'(1));

  // NOTE: FIFO storage has no reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tdr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
    end else if (tx_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   tx_count <= tx_count + (FIFO_AW+1)'(1);
        2'b01:   tx_count <= tx_count - (FIFO_AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           tx_overrun <= 1'b0;
    else if (tx_reset)    tx_overrun <= 1'b0;
    else if (overrun_set) tx_overrun <= 1'b1;
    else if (sr_read)     tx_overrun <= 1'b0;
  end

  // txd is loaded with the level of the state being entered, so it is a pure register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      txd        <= 1'b1;
      shift_q    <= '0;
      bit_cnt    <= '0;
      baud_cnt   <= '0;
      div_q      <= DIV_W'(1);
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else if (tx_reset) begin
      state    <= S_IDLE;
      txd      <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      if (state != S_IDLE) baud_cnt <= baud_end ? '0 : baud_cnt + DIV_W'(1);
      case (state)
        S_IDLE: begin
          if (pop) begin
            state      <= S_START;
            txd        <= 1'b0;
            shift_q    <= mem[rd_ptr];
            par_bit_q  <= (^mem[rd_ptr]) ^ parity_odd;
            par_en_q   <= parity_en;
            two_stop_q <= two_stop;
            div_q      <= (baud_div == '0) ? DIV_W'(1) : baud_div;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
          end
        end
        S_START: begin
          if (baud_end) begin
            state <= S_DATA;
            txd   <= shift_q[0];
          end
        end
        S_DATA: begin
          if (baud_end) begin
            shift_q <= shift_q >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (par_en_q) begin
                state <= S_PARITY;
                txd   <= par_bit_q;
              end else begin
                state <= S_STOP;
                txd   <= 1'b1;
              end
            end else begin
              txd <= shift_q[1];
            end
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            state   <= S_STOP;
            txd     <= 1'b1;
            bit_cnt <= '0;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            if (two_stop_q && bit_cnt == 3'd0) begin
              bit_cnt <= 3'd1;
            end else begin
              state   <= S_IDLE;
              txd     <= 1'b1;
              bit_cnt <= '0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
